lfsr_seq_checker: RTL and testbench

//  Receive-side checker for the 12-bit Galois LFSR random-number stream (seed 12'hAA7).

---
 rtl/lfsr_seq_checker.sv | 154 +++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// End-of-link checker for the 12-bit Galois LFSR stream: self-syncs or loads the seed,
// then predicts each word, flagging/counting mismatches and the all-zero lock-up word.
module lfsr_seq_checker #(
    parameter logic [11:0] SEED     = 12'hAA7,
    parameter logic [11:0] MASK     = 12'hA97,
    parameter int          LOCK_CNT = 4,
    parameter int          LOSS_CNT = 3,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load_data,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [11:0]      in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             stuck_zero,
    output logic             o_dbg_state
);

    localparam int MR_W = $clog2(LOCK_CNT + 1);
    localparam int XR_W = $clog2(LOSS_CNT + 1);
    localparam logic [MR_W-1:0] LOCK_V = MR_W'(LOCK_CNT);
    localparam logic [XR_W-1:0] LOSS_V = XR_W'(LOSS_CNT);

    typedef enum logic {
        S_HUNT   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [11:0]      r_exp;
    logic [11:0]      w_exp_nxt;
    logic [MR_W-1:0]  r_mrun;
    logic [MR_W-1:0]  w_mrun_nxt;
    logic [MR_W-1:0]  w_mrun_inc;
    logic [XR_W-1:0]  r_xrun;
    logic [XR_W-1:0]  w_xrun_nxt;
    logic [XR_W-1:0]  w_xrun_inc;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] w_err_nxt;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] w_word_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_stuck;
    logic             w_stuck_nxt;
    logic             w_match;

    function automatic logic [11:0] f_next(input logic [11:0] s);
        return {s[10:0], 1'b0} ^ (s[11] ? MASK : 12'h000);
    endfunction

    assign w_match    = (in_data == r_exp);
    assign w_mrun_inc = r_mrun + MR_W'(1);
    assign w_xrun_inc = r_xrun + XR_W'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_HUNT;
            r_exp      <= SEED;
            r_mrun     <= '0;
            r_xrun     <= '0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
            r_pulse    <= 1'b0;
            r_stuck    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_exp      <= w_exp_nxt;
            r_mrun     <= w_mrun_nxt;
            r_xrun     <= w_xrun_nxt;
            r_err_cnt  <= w_err_nxt;
            r_word_cnt <= w_word_nxt;
            r_pulse    <= w_pulse_nxt;
            r_stuck    <= w_stuck_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_mrun_nxt  = r_mrun;
        w_xrun_nxt  = r_xrun;
        w_err_nxt   = r_err_cnt;
        w_word_nxt  = r_word_cnt;
        w_pulse_nxt = 1'b0;
        w_stuck_nxt = r_stuck;

        if (load_data) begin
            // The word presented alongside a load is deliberately ignored.
            w_state_nxt = S_LOCKED;
            w_exp_nxt   = SEED;
            w_mrun_nxt  = '0;
            w_xrun_nxt  = '0;
            w_stuck_nxt = 1'b0;
        end else if (in_valid) begin
            if (in_data == 12'h000) begin
                w_stuck_nxt = 1'b1;
            end
            if (r_state == S_HUNT) begin
                w_exp_nxt = f_next(in_data);
                if (w_match) begin
                    w_mrun_nxt = w_mrun_inc;
                    if (w_mrun_inc == LOCK_V) begin
                        w_state_nxt = S_LOCKED;
                        w_xrun_nxt  = '0;
                    end
                end else begin
                    w_mrun_nxt = '0;
                end
            end else begin
                // Free-run the prediction so a corrupted word cannot derail it.
                w_exp_nxt = f_next(r_exp);
                if (r_word_cnt != '1) begin
                    w_word_nxt = r_word_cnt + CNT_W'(1);
                end
                if (w_match) begin
                    w_xrun_nxt = '0;
                end else begin
                    w_pulse_nxt = 1'b1;
                    if (r_err_cnt != '1) begin
                        w_err_nxt = r_err_cnt + CNT_W'(1);
                    end
                    w_xrun_nxt = w_xrun_inc;
                    if (w_xrun_inc == LOSS_V) begin
                        w_state_nxt = S_HUNT;
                        w_mrun_nxt  = '0;
                    end
                end
            end
        end

        // Clear wins over the same cycle's word update.
        if (clr) begin
            w_err_nxt   = '0;
            w_word_nxt  = '0;
            w_pulse_nxt = 1'b0;
            w_stuck_nxt = 1'b0;
        end
    end

    assign locked      = (r_state == S_LOCKED);
    assign err_pulse   = r_pulse;
    assign err_cnt     = r_err_cnt;
    assign word_cnt    = r_word_cnt;
    assign stuck_zero  = r_stuck;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios plus randomized traffic against a
// reference model built from the stream rules; a second instance covers saturation.
module tb_lfsr_seq_checker;

    logic        CLK;
    logic        RST_N;
    logic        load_data, clr, in_valid;
    logic [11:0] in_data;
    logic        locked, err_pulse, stuck_zero, dbg_state;
    logic [15:0] err_cnt, word_cnt;

    logic        rst2_n, ld2, v2;
    logic [11:0] d2;
    logic        locked2, pulse2, stuck2, dbg2;
    logic [3:0]  err2, word2;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [11:0] m_exp;
    logic        m_locked, m_pulse, m_stuck;
    int          m_mrun, m_xrun;
    int          m_err, m_word;

    lfsr_seq_checker dut (
        .CLK(CLK), .RST_N(RST_N), .load_data(load_data), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .locked(locked),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .word_cnt(word_cnt),
        .stuck_zero(stuck_zero), .o_dbg_state(dbg_state)
    );

    lfsr_seq_checker #(.LOSS_CNT(32), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RST_N(rst2_n), .load_data(ld2), .clr(1'b0),
        .in_valid(v2), .in_data(d2), .locked(locked2),
        .err_pulse(pulse2), .err_cnt(err2), .word_cnt(word2),
        .stuck_zero(stuck2), .o_dbg_state(dbg2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [11:0] ref_next(input logic [11:0] s);
        int v;
        v = int'(s) * 2;
        if (v >= 4096) v = (v - 4096) ^ 32'hA97;
        return v[11:0];
    endfunction

    task automatic model_reset();
        m_exp = 12'hAA7; m_locked = 1'b0; m_pulse = 1'b0; m_stuck = 1'b0;
        m_mrun = 0; m_xrun = 0; m_err = 0; m_word = 0;
    endtask

    task automatic model_step(input logic ld, input logic cl, input logic v, input logic [11:0] d);
        m_pulse = 1'b0;
        if (ld) begin
            m_exp = 12'hAA7; m_locked = 1'b1; m_mrun = 0; m_xrun = 0; m_stuck = 1'b0;
        end else if (v) begin
            if (d == 12'h000) m_stuck = 1'b1;
            if (!m_locked) begin
                m_mrun = (d == m_exp) ? m_mrun + 1 : 0;
                m_exp  = ref_next(d);
                if (m_mrun == 4) begin m_locked = 1'b1; m_xrun = 0; end
            end else begin
                if (m_word < 65535) m_word++;
                if (d == m_exp) m_xrun = 0;
                else begin
                    m_pulse = 1'b1;
                    if (m_err < 65535) m_err++;
                    m_xrun++;
                    if (m_xrun == 3) begin m_locked = 1'b0; m_mrun = 0; end
                end
                m_exp = ref_next(m_exp);
            end
        end
        if (cl) begin m_err = 0; m_word = 0; m_pulse = 1'b0; m_stuck = 1'b0; end
    endtask

    // One clock of stimulus on the main instance; outputs are stable on return.
    task automatic drive(input logic ld, input logic cl, input logic v, input logic [11:0] d);
        @(negedge CLK);
        load_data = ld; clr = cl; in_valid = v; in_data = d;
        @(posedge CLK);
        model_step(ld, cl, v, d);
        #1;
        load_data = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 12'h000;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; load_data = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 12'h000;
        rst2_n = 1'b0; ld2 = 1'b0; v2 = 1'b0; d2 = 12'h000;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", locked); end
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %0b want 0", err_pulse); end
        n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        n_tests++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
        n_tests++; if (stuck_zero !== 1'b0) begin n_fail++; $display("FAIL reset_stuck: got %0b want 0", stuck_zero); end
        @(negedge CLK);
        RST_N = 1'b1; rst2_n = 1'b1;
    endtask

    task automatic test_lock_from_reset();
        drive(1'b0, 1'b0, 1'b1, 12'hAA7);
        drive(1'b0, 1'b0, 1'b1, 12'hFD9);
        drive(1'b0, 1'b0, 1'b1, 12'h525);
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL early_lock: got %0b want 0", locked); end
        drive(1'b0, 1'b0, 1'b1, 12'hA4A);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_after_a4a: got %0b want 1", locked); end
        n_tests++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL hunt_no_count: got %0d want 0", word_cnt); end
        drive(1'b0, 1'b0, 1'b1, 12'hE03);
        n_tests++; if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL e03_word_cnt: got %0d want 1", word_cnt); end
        n_tests++; if (err_cnt !== 16'd0 || err_pulse !== 1'b0) begin n_fail++; $display("FAIL e03_no_err: got cnt=%0d pulse=%0b want 0/0", err_cnt, err_pulse); end
    endtask

    task automatic test_load_error();
        drive(1'b1, 1'b1, 1'b0, 12'h000);
        drive(1'b0, 1'b0, 1'b1, 12'hAA7);
        drive(1'b0, 1'b0, 1'b1, 12'hFD9);
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL pre_err_pulse: got %0b want 0", err_pulse); end
        drive(1'b0, 1'b0, 1'b1, 12'h524);
        n_tests++; if (err_pulse !== 1'b1 || err_cnt !== 16'd1) begin n_fail++; $display("FAIL err_on_524: got pulse=%0b cnt=%0d want 1/1", err_pulse, err_cnt); end
        drive(1'b0, 1'b0, 1'b1, 12'hA4A);
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_one_cycle: got %0b want 0", err_pulse); end
        n_tests++; if (locked !== 1'b1 || word_cnt !== 16'd4 || err_cnt !== 16'd1) begin n_fail++; $display("FAIL after_a4a: got lock=%0b words=%0d errs=%0d want 1/4/1", locked, word_cnt, err_cnt); end
    endtask

    task automatic test_loss_relock();
        logic [11:0] seq [5];
        seq[0] = 12'h525; seq[1] = 12'hA4A; seq[2] = 12'hE03;
        seq[3] = ref_next(seq[2]); seq[4] = ref_next(seq[3]);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, m_exp ^ 12'h010);
            if (i == 1) begin
                n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL hold_after_2_miss: got %0b want 1", locked); end
            end
        end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL drop_after_3_miss: got %0b want 0", locked); end
        n_tests++; if (err_cnt !== 16'd4) begin n_fail++; $display("FAIL miss_err_cnt: got %0d want 4", err_cnt); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, seq[i]);
            if (i == 3) begin
                n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %0b want 0", locked); end
            end
        end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_5th: got %0b want 1", locked); end
        n_tests++; if (word_cnt !== 16'd7 || err_cnt !== 16'd4) begin n_fail++; $display("FAIL relock_counts: got words=%0d errs=%0d want 7/4", word_cnt, err_cnt); end
    endtask

    task automatic test_stuck_clr();
        drive(1'b0, 1'b0, 1'b1, 12'h000);
        n_tests++; if (stuck_zero !== 1'b1) begin n_fail++; $display("FAIL stuck_set: got %0b want 1", stuck_zero); end
        drive(1'b0, 1'b0, 1'b1, m_exp);
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        drive(1'b0, 1'b0, 1'b1, m_exp);
        n_tests++; if (stuck_zero !== 1'b1) begin n_fail++; $display("FAIL stuck_sticky: got %0b want 1", stuck_zero); end
        drive(1'b0, 1'b1, 1'b1, m_exp ^ 12'h001);
        n_tests++; if (stuck_zero !== 1'b0 || err_cnt !== 16'd0 || word_cnt !== 16'd0 || err_pulse !== 1'b0) begin
            n_fail++; $display("FAIL clr_all: got stuck=%0b errs=%0d words=%0d pulse=%0b want 0/0/0/0", stuck_zero, err_cnt, word_cnt, err_pulse);
        end
    endtask

    task automatic test_random();
        int r, sel, bad;
        logic ld, cl, v;
        logic [11:0] d;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            r   = $urandom_range(0, 99);
            ld  = (r < 3);
            cl  = (r >= 3 && r < 6);
            v   = ($urandom_range(0, 9) != 0);
            sel = $urandom_range(0, 29);
            if (sel < 22) d = m_exp;
            else if (sel < 25) d = m_exp ^ 12'(1 << $urandom_range(0, 11));
            else if (sel < 29) d = 12'($urandom_range(1, 4095));
            else d = 12'h000;
            drive(ld, cl, v, d);
            n_tests++;
            if (locked !== m_locked || err_pulse !== m_pulse || stuck_zero !== m_stuck ||
                err_cnt !== 16'(m_err) || word_cnt !== 16'(m_word)) begin
                n_fail++;
                if (bad < 10) $display("FAIL random_%0d: got lock=%0b pulse=%0b stuck=%0b errs=%0d words=%0d want %0b/%0b/%0b/%0d/%0d",
                    i, locked, err_pulse, stuck_zero, err_cnt, word_cnt, m_locked, m_pulse, m_stuck, m_err, m_word);
                bad++;
            end
        end
    endtask

    task automatic test_saturate_async_reset();
        @(negedge CLK); ld2 = 1'b1;
        @(negedge CLK); ld2 = 1'b0; v2 = 1'b1; d2 = 12'h000;
        repeat (10) @(negedge CLK);
        n_tests++; if (err2 !== 4'd10) begin n_fail++; $display("FAIL sat_mid: got %0d want 10", err2); end
        repeat (10) @(negedge CLK);
        n_tests++; if (err2 !== 4'd15 || word2 !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got errs=%0d words=%0d want 15/15", err2, word2); end
        n_tests++; if (locked2 !== 1'b1 || pulse2 !== 1'b1 || stuck2 !== 1'b1) begin n_fail++; $display("FAIL sat_flags: got lock=%0b pulse=%0b stuck=%0b want 1/1/1", locked2, pulse2, stuck2); end
        @(posedge CLK); #2;
        rst2_n = 1'b0;
        #1;
        n_tests++; if ({locked2, pulse2, stuck2} !== 3'b000 || err2 !== 4'd0 || word2 !== 4'd0) begin
            n_fail++; $display("FAIL async_reset: got lock=%0b pulse=%0b stuck=%0b errs=%0d words=%0d want all 0", locked2, pulse2, stuck2, err2, word2);
        end
        v2 = 1'b0;
        @(negedge CLK); rst2_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock_from_reset();
        test_load_error();
        test_loss_relock();
        test_stuck_clr();
        test_random();
        test_saturate_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
